// File: rtl/proc_pkg.sv
// Shared encodings for the simple-processor control unit: opcodes, bus selects,
// ALU codes, step encoding and instruction field positions.
package proc_pkg;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b110;

    localparam logic [3:0] SEL_NONE = 4'd0;
    localparam logic [3:0] SEL_IMM  = 4'd8;
    localparam logic [3:0] SEL_G    = 4'd9;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;

    localparam int OP_HI = 15;
    localparam int OP_LO = 13;
    localparam int M_BIT = 12;
    localparam int RX_HI = 11;
    localparam int RX_LO = 9;
    localparam int RY_HI = 2;
    localparam int RY_LO = 0;

    function automatic logic is_alu(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

    function automatic logic [1:0] alu_code(input logic [2:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/proc_decode.sv
// Combinational step decoder: maps the current step and IR to datapath
// control strobes and the next step.
module proc_decode
    import proc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  state_t            state,
    input  logic              run,
    input  logic [DATA_W-1:0] ir,
    output logic [3:0]        bus_sel,
    output logic [NREG-1:0]   r_in,
    output logic              a_in,
    output logic              g_in,
    output logic [1:0]        alu_op,
    output logic              done,
    output logic              illegal,
    output state_t            next_state
);

    logic [2:0] op;
    logic       imm;
    logic [2:0] rx;
    logic [2:0] ry;
    logic       unused_ir;

    assign op        = ir[OP_HI:OP_LO];
    assign imm       = ir[M_BIT];
    assign rx        = ir[RX_HI:RX_LO];
    assign ry        = ir[RY_HI:RY_LO];
    assign unused_ir = ^ir[RX_LO-1:RY_HI+1];

    function automatic logic [NREG-1:0] onehot(input logic [2:0] idx);
        logic [NREG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_comb begin
        bus_sel    = SEL_NONE;
        r_in       = '0;
        a_in       = 1'b0;
        g_in       = 1'b0;
        alu_op     = ALU_ADD;
        done       = 1'b0;
        illegal    = 1'b0;
        next_state = state;

        case (state)
            T0: begin
                if (run) next_state = T1;
            end
            T1: begin
                next_state = T0;
                case (op)
                    OP_MV: begin
                        bus_sel = imm ? SEL_IMM : {1'b0, ry};
                        r_in    = onehot(rx);
                        done    = 1'b1;
                    end
                    OP_MVT: begin
                        // Register-form MVT is a NOP that still completes
                        if (imm) begin
                            bus_sel = SEL_IMM;
                            r_in    = onehot(rx);
                        end
                        done = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        bus_sel    = {1'b0, rx};
                        a_in       = 1'b1;
                        next_state = T2;
                    end
                    default: begin
                        done    = 1'b1;
                        illegal = 1'b1;
                    end
                endcase
            end
            T2: begin
                next_state = T0;
                if (is_alu(op)) begin
                    bus_sel    = imm ? SEL_IMM : {1'b0, ry};
                    g_in       = 1'b1;
                    alu_op     = alu_code(op);
                    next_state = T3;
                end
            end
            T3: begin
                bus_sel    = SEL_G;
                r_in       = onehot(rx);
                done       = 1'b1;
                next_state = T0;
            end
            default: next_state = T0;
        endcase
    end

endmodule

// File: rtl/proc_ctrl.sv
// Processor control unit: holds the step register and IR, and gates the
// decoded control strobes off while reset is asserted.
module proc_ctrl
    import proc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] ir,
    output logic [3:0]        bus_sel,
    output logic [NREG-1:0]   r_in,
    output logic              a_in,
    output logic              g_in,
    output logic [1:0]        alu_op,
    output logic              done,
    output logic              illegal
);

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] ir_reg;

    logic [3:0]        dec_bus_sel;
    logic [NREG-1:0]   dec_r_in;
    logic              dec_a_in;
    logic              dec_g_in;
    logic [1:0]        dec_alu_op;
    logic              dec_done;
    logic              dec_illegal;

    proc_decode #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_decode (
        .state      (state),
        .run        (run),
        .ir         (ir_reg),
        .bus_sel    (dec_bus_sel),
        .r_in       (dec_r_in),
        .a_in       (dec_a_in),
        .g_in       (dec_g_in),
        .alu_op     (dec_alu_op),
        .done       (dec_done),
        .illegal    (dec_illegal),
        .next_state (next_state)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= T0;
            ir_reg <= '0;
        end else begin
            state <= next_state;
            if (state == T0 && run) ir_reg <= din;
        end
    end

    assign ir = ir_reg;

    // Strobes are killed in the reset cycle so no partial write-back lands
    always_comb begin
        bus_sel = SEL_NONE;
        r_in    = '0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        alu_op  = ALU_ADD;
        done    = 1'b0;
        illegal = 1'b0;
        if (!reset) begin
            bus_sel = dec_bus_sel;
            r_in    = dec_r_in;
            a_in    = dec_a_in;
            g_in    = dec_g_in;
            alu_op  = dec_alu_op;
            done    = dec_done;
            illegal = dec_illegal;
        end
    end

endmodule

// File: tb/tb_proc_ctrl.sv
// Scoreboard bench for proc_ctrl: per-cycle expected control vectors are queued
// as each instruction is issued and compared on the falling edge.
module tb_proc_ctrl;

    logic        clk;
    logic        reset;
    logic        run;
    logic [15:0] din;
    logic [15:0] ir;
    logic [3:0]  bus_sel;
    logic [7:0]  r_in;
    logic        a_in;
    logic        g_in;
    logic [1:0]  alu_op;
    logic        done;
    logic        illegal;

    logic [33:0] obs;
    logic [33:0] exp_v;
    logic [33:0] sb[$];
    int          total;
    int          bad;

    proc_ctrl #(
        .DATA_W (16),
        .NREG   (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .din     (din),
        .ir      (ir),
        .bus_sel (bus_sel),
        .r_in    (r_in),
        .a_in    (a_in),
        .g_in    (g_in),
        .alu_op  (alu_op),
        .done    (done),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {ir, bus_sel, r_in, a_in, g_in, alu_op, done, illegal};

    function automatic logic [33:0] mk(input logic [15:0] i, input logic [3:0] s,
                                       input logic [7:0] r, input logic a, input logic g,
                                       input logic [1:0] op, input logic d, input logic il);
        return {i, s, r, a, g, op, d, il};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch(input logic [15:0] word);
        din = word;
        run = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run   = 1'b1;
        din   = 16'h4606;
        for (int i = 0; i < 3; i++) sb.push_back(mk(16'h0, 4'd0, 8'h00, 0, 0, 2'd0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            step();
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL reset_hold[%0d] got=%h want=%h", i, obs, exp_v);
            end
        end
        reset = 1'b0;
        run   = 1'b0;
        for (int i = 0; i < 2; i++) sb.push_back(mk(16'h0, 4'd0, 8'h00, 0, 0, 2'd0, 0, 0));
        for (int i = 0; i < 2; i++) begin
            step();
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL reset_idle[%0d] got=%h want=%h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_mv();
        logic [15:0] words [2];
        logic [3:0]  sels  [2];
        logic [7:0]  rins  [2];
        words = '{16'h1005, 16'h0A02};
        sels  = '{4'd8, 4'd2};
        rins  = '{8'h01, 8'h20};
        for (int k = 0; k < 2; k++) begin
            fetch(words[k]);
            sb.push_back(mk(words[k], sels[k], rins[k], 0, 0, 2'd0, 1, 0));
            sb.push_back(mk(words[k], 4'd0, 8'h00, 0, 0, 2'd0, 0, 0));
            sb.push_back(mk(words[k], 4'd0, 8'h00, 0, 0, 2'd0, 0, 0));
            for (int i = 0; i < 3; i++) begin
                step();
                if (i == 0) run = 1'b0;
                exp_v = sb.pop_front();
                total++;
                if (obs !== exp_v) begin
                    bad++;
                    $display("FAIL mv_%h[%0d] got=%h want=%h", words[k], i, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_mvt();
        fetch(16'h3E00);
        sb.push_back(mk(16'h3E00, 4'd8, 8'h80, 0, 0, 2'd0, 1, 0));
        sb.push_back(mk(16'h3E00, 4'd0, 8'h00, 0, 0, 2'd0, 0, 0));
        for (int i = 0; i < 2; i++) begin
            step();
            if (i == 0) run = 1'b0;
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL mvt_imm[%0d] got=%h want=%h", i, obs, exp_v);
            end
        end
        fetch(16'h2205);
        sb.push_back(mk(16'h2205, 4'd0, 8'h00, 0, 0, 2'd0, 1, 0));
        sb.push_back(mk(16'h2205, 4'd0, 8'h00, 0, 0, 2'd0, 0, 0));
        for (int i = 0; i < 2; i++) begin
            step();
            if (i == 0) run = 1'b0;
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL mvt_nop[%0d] got=%h want=%h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_add();
        fetch(16'h4606);
        sb.push_back(mk(16'h4606, 4'd3, 8'h00, 1, 0, 2'b00, 0, 0));
        sb.push_back(mk(16'h4606, 4'd6, 8'h00, 0, 1, 2'b00, 0, 0));
        sb.push_back(mk(16'h4606, 4'd9, 8'h08, 0, 0, 2'b00, 1, 0));
        sb.push_back(mk(16'h4606, 4'd0, 8'h00, 0, 0, 2'b00, 0, 0));
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) run = 1'b0;
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL add[%0d] got=%h want=%h", i, obs, exp_v);
            end
        end
    endtask

    // SUB R1,#4 with run held, then AND R2,R2 fetched in the very next T0
    task automatic test_back_to_back();
        fetch(16'h7204);
        sb.push_back(mk(16'h7204, 4'd1, 8'h00, 1, 0, 2'b00, 0, 0));
        sb.push_back(mk(16'h7204, 4'd8, 8'h00, 0, 1, 2'b01, 0, 0));
        sb.push_back(mk(16'h7204, 4'd9, 8'h02, 0, 0, 2'b00, 1, 0));
        sb.push_back(mk(16'h7204, 4'd0, 8'h00, 0, 0, 2'b00, 0, 0));
        sb.push_back(mk(16'hC402, 4'd2, 8'h00, 1, 0, 2'b00, 0, 0));
        sb.push_back(mk(16'hC402, 4'd2, 8'h00, 0, 1, 2'b10, 0, 0));
        sb.push_back(mk(16'hC402, 4'd9, 8'h04, 0, 0, 2'b00, 1, 0));
        sb.push_back(mk(16'hC402, 4'd0, 8'h00, 0, 0, 2'b00, 0, 0));
        sb.push_back(mk(16'hC402, 4'd0, 8'h00, 0, 0, 2'b00, 0, 0));
        for (int i = 0; i < 9; i++) begin
            step();
            if (i == 0) din = 16'hC402;
            if (i == 6) run = 1'b0;
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL b2b[%0d] got=%h want=%h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_reserved();
        logic [15:0] words [3];
        words = '{16'h8000, 16'hA3C7, 16'hE000};
        for (int k = 0; k < 3; k++) begin
            fetch(words[k]);
            sb.push_back(mk(words[k], 4'd0, 8'h00, 0, 0, 2'd0, 1, 1));
            sb.push_back(mk(words[k], 4'd0, 8'h00, 0, 0, 2'd0, 0, 0));
            for (int i = 0; i < 2; i++) begin
                step();
                if (i == 0) run = 1'b0;
                exp_v = sb.pop_front();
                total++;
                if (obs !== exp_v) begin
                    bad++;
                    $display("FAIL reserved_%h[%0d] got=%h want=%h", words[k], i, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        fetch(16'h4606);
        sb.push_back(mk(16'h4606, 4'd3, 8'h00, 1, 0, 2'b00, 0, 0));
        sb.push_back(mk(16'h4606, 4'd6, 8'h00, 0, 1, 2'b00, 0, 0));
        for (int i = 0; i < 2; i++) begin
            step();
            if (i == 0) run = 1'b0;
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL rstmid_pre[%0d] got=%h want=%h", i, obs, exp_v);
            end
        end
        reset = 1'b1;
        #1;
        sb.push_back(mk(16'h4606, 4'd0, 8'h00, 0, 0, 2'b00, 0, 0));
        exp_v = sb.pop_front();
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL rstmid_gate got=%h want=%h", obs, exp_v);
        end
        sb.push_back(mk(16'h0000, 4'd0, 8'h00, 0, 0, 2'b00, 0, 0));
        sb.push_back(mk(16'h0000, 4'd0, 8'h00, 0, 0, 2'b00, 0, 0));
        sb.push_back(mk(16'h0000, 4'd0, 8'h00, 0, 0, 2'b00, 0, 0));
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 0) reset = 1'b0;
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL rstmid_post[%0d] got=%h want=%h", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        run   = 1'b0;
        din   = 16'h0;
        @(negedge clk);
        test_reset();
        test_mv();
        test_mvt();
        test_add();
        test_back_to_back();
        test_reserved();
        test_reset_mid();
        test_mv();
        if (sb.size() != 0) begin
            bad++;
            total++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
